// File: rtl/rblwe_pkg.sv
// ============================================================================
//  Module   : rblwe_pkg
//  Purpose  : Shared types and helpers for the Ring-Binary-LWE decrypt core.
//             Holds the controller state enum, the r2 coefficient width and
//             encodings, the message decode function and index-width helpers.
//  Config   : RBLWE_TERNARY_EN selects ternary r2 (RW=2) instead of binary
//             (RW=1).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rblwe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

`ifdef RBLWE_TERNARY_EN
    localparam int RW = 2;
`else
    localparam int RW = 1;
`endif

    // Ternary r2 encodings; 2'b00 and 2'b10 both mean zero.
    localparam logic [1:0] R2_POS = 2'b01;
    localparam logic [1:0] R2_NEG = 2'b11;

    // Index width that never collapses to zero bits (e.g. a single block).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // A coefficient decodes to 1 iff it lies in [q/4, 3q/4).
    function automatic logic decode_bit(input logic msb, input logic msb1);
        return msb ^ msb1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rblwe_decrypt_core_if.sv
// ============================================================================
//  Module   : rblwe_decrypt_core_if
//  Purpose  : Load/start/result bundle of the RBLWE decrypt core.
//  Ports    : load, c1_in, c2_in, r2_in, start  (master -> core)
//             busy, message_out, valid, done    (core -> master)
//  Config   : r2_in width follows RW (RBLWE_TERNARY_EN).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rblwe_decrypt_core_if #(
    parameter int LOGQ = 8
);
    import rblwe_pkg::*;

    logic            load;
    logic [LOGQ-1:0] c1_in;
    logic [LOGQ-1:0] c2_in;
    logic [RW-1:0]   r2_in;
    logic            start;
    logic            busy;
    logic            message_out;
    logic            valid;
    logic            done;

    modport master (
        output load, c1_in, c2_in, r2_in, start,
        input  busy, message_out, valid, done
    );

    modport slave (
        input  load, c1_in, c2_in, r2_in, start,
        output busy, message_out, valid, done
    );

endinterface

`default_nettype wire

// File: rtl/rblwe_mac_lane.sv
// ============================================================================
//  Module   : rblwe_mac_lane
//  Purpose  : One multiply-accumulate lane: acc +/- c1 depending on the r2
//             coefficient and the negacyclic wrap flag, mod 2^LOGQ.
//  Ports    : acc_i  accumulator word in      c1_i   c1 word
//             wrap_i k<j (negate the term)    r2_i   r2 coefficient
//             acc_o  updated accumulator word
//  Config   : RBLWE_TERNARY_EN adds the r2 = -1 subtract path.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rblwe_mac_lane
    import rblwe_pkg::*;
#(
    parameter int LOGQ = 8
) (
    input  logic [LOGQ-1:0] acc_i,
    input  logic [LOGQ-1:0] c1_i,
    input  logic            wrap_i,
    input  logic [RW-1:0]   r2_i,
    output logic [LOGQ-1:0] acc_o
);

    logic w_add;
    logic w_neg;

`ifdef RBLWE_TERNARY_EN
    assign w_add = (r2_i == R2_POS) || (r2_i == R2_NEG);
    // A -1 coefficient and the wrap sign cancel each other.
    assign w_neg = (r2_i == R2_NEG) ^ wrap_i;
`else
    assign w_add = r2_i[0];
    assign w_neg = wrap_i;
`endif

    always_comb begin
        acc_o = acc_i;
        if (w_add) begin
            acc_o = w_neg ? (acc_i - c1_i) : (acc_i + c1_i);
        end
    end

endmodule

`default_nettype wire

// File: rtl/rblwe_decrypt_core.sv
// ============================================================================
//  Module   : rblwe_decrypt_core
//  Purpose  : Ring-Binary-LWE decryption m = decode(c1*r2 + c2) in
//             Z_q[x]/(x^N+1), q = 2^LOGQ, using P parallel MAC lanes.
//  Ports    : clk      rising-edge clock
//             reset_n  asynchronous active-low reset
//             bus      rblwe_decrypt_core_if.slave (load/coefficients/start
//                      in, busy/message_out/valid/done out)
//  Config   : RBLWE_TERNARY_EN - ternary r2 coefficients (RW=2).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rblwe_decrypt_core
    import rblwe_pkg::*;
#(
    parameter int N    = 256,
    parameter int LOGQ = 8,
    parameter int P    = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    rblwe_decrypt_core_if.slave  bus
);

    localparam int LN = idx_w(N);
    localparam int NB = N / P;
    localparam int LB = idx_w(NB);
    localparam int CW = $clog2(N) + 1;

    // Coefficient storage; contents are not reset.
    logic [LOGQ-1:0] c1_q  [N];
    logic [RW-1:0]   r2_q  [N];
    logic [LOGQ-1:0] acc_q [N];

    state_t          state_q,  state_d;
    logic [LN-1:0]   j_q,      j_d;
    logic [LB-1:0]   blk_q,    blk_d;
    logic [LN-1:0]   oidx_q,   oidx_d;
    logic [CW-1:0]   cnt_q,    cnt_d;
    logic            done_q,   done_d;

    logic            w_load_we;
    logic [LN-1:0]   w_load_k;

    logic [LN-1:0]   w_k       [P];
    logic [LN-1:0]   w_cidx    [P];
    logic [LOGQ-1:0] w_acc_new [P];

    // Lane l of block b handles accumulator index k = b*P + l; its c1 operand
    // is c1[(k-j) mod N], which the LN-bit subtraction wraps for free.
    for (genvar l = 0; l < P; l++) begin : g_lane
        assign w_k[l]    = LN'(int'(blk_q) * P + l);
        assign w_cidx[l] = w_k[l] - j_q;

        rblwe_mac_lane #(.LOGQ(LOGQ)) u_lane (
            .acc_i  (acc_q[w_k[l]]),
            .c1_i   (c1_q[w_cidx[l]]),
            .wrap_i (w_k[l] < j_q),
            .r2_i   (r2_q[j_q]),
            .acc_o  (w_acc_new[l])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            j_q     <= '0;
            blk_q   <= '0;
            oidx_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            blk_q   <= blk_d;
            oidx_q  <= oidx_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        j_d       = j_q;
        blk_d     = blk_q;
        oidx_d    = oidx_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        w_load_we = 1'b0;
        // When cnt_q == N its low LN bits are zero, so a load after a full
        // frame naturally restarts at k = 0.
        w_load_k  = cnt_q[LN-1:0];

        case (state_q)
            ST_IDLE: begin
                // start has priority; a load in the same cycle is dropped.
                if (bus.start && (cnt_q == CW'(N))) begin
                    state_d = ST_MULT;
                    cnt_d   = '0;
                    j_d     = '0;
                    blk_d   = '0;
                end else if (bus.load) begin
                    w_load_we = 1'b1;
                    cnt_d     = (cnt_q == CW'(N)) ? CW'(1) : cnt_q + 1'b1;
                end
            end
            ST_MULT: begin
                if (blk_q == LB'(NB - 1)) begin
                    blk_d = '0;
                    if (j_q == LN'(N - 1)) begin
                        state_d = ST_OUT;
                        oidx_d  = '0;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end else begin
                    blk_d = blk_q + 1'b1;
                end
            end
            ST_OUT: begin
                if (oidx_q == LN'(N - 1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    oidx_d = oidx_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Accumulator is pre-seeded with c2 at load time and updated in place.
    always_ff @(posedge clk) begin
        if (w_load_we) begin
            c1_q[w_load_k]  <= bus.c1_in;
            r2_q[w_load_k]  <= bus.r2_in;
            acc_q[w_load_k] <= bus.c2_in;
        end else if (state_q == ST_MULT) begin
            for (int l = 0; l < P; l++) begin
                acc_q[w_k[l]] <= w_acc_new[l];
            end
        end
    end

    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.valid       = (state_q == ST_OUT);
    assign bus.message_out = (state_q == ST_OUT) &&
                             decode_bit(acc_q[oidx_q][LOGQ-1], acc_q[oidx_q][LOGQ-2]);
    assign bus.done        = done_q;

endmodule

`default_nettype wire

// File: tb/tb_rblwe_decrypt_core.sv
// ============================================================================
//  Module   : tb_rblwe_decrypt_core
//  Purpose  : Self-checking bench for rblwe_decrypt_core at N=4, LOGQ=8, P=2.
//             Directed vectors, protocol corner cases and random frames
//             checked against a negacyclic polynomial-product model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rblwe_decrypt_core;
    import rblwe_pkg::*;

    localparam int N    = 4;
    localparam int LOGQ = 8;
    localparam int P    = 2;
    localparam int MC   = N * N / P;
    localparam int Q    = 1 << LOGQ;

    typedef struct {
        logic [LOGQ-1:0] c1 [N];
        logic [LOGQ-1:0] c2 [N];
        logic [RW-1:0]   r2 [N];
        logic [N-1:0]    bits;
    } vec_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;
    int   n_pass  = 0;
    int   n_chk   = 0;

    rblwe_decrypt_core_if #(.LOGQ(LOGQ)) bus ();

    rblwe_decrypt_core #(.N(N), .LOGQ(LOGQ), .P(P)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int r2val(input logic [RW-1:0] r);
`ifdef RBLWE_TERNARY_EN
        case (r)
            2'b01:   return 1;
            2'b11:   return -1;
            default: return 0;
        endcase
`else
        return r[0] ? 1 : 0;
`endif
    endfunction

    // c1*r2 + c2 in Z_q[x]/(x^N+1): x^(a+b) with a+b >= N folds back negated.
    function automatic logic [N-1:0] model(input vec_t v);
        int acc [N];
        logic [N-1:0] m;
        for (int i = 0; i < N; i++) acc[i] = int'(v.c2[i]);
        for (int a = 0; a < N; a++) begin
            for (int b = 0; b < N; b++) begin
                int t = a + b;
                int p = r2val(v.r2[b]) * int'(v.c1[a]);
                if (t >= N) begin
                    t -= N;
                    p = -p;
                end
                acc[t] += p;
            end
        end
        for (int i = 0; i < N; i++) begin
            int x = ((acc[i] % Q) + Q) % Q;
            m[i] = (x >= Q / 4) && (x < 3 * Q / 4);
        end
        return m;
    endfunction

    task automatic load_range(input vec_t v, input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            bus.load  = 1'b1;
            bus.c1_in = v.c1[k];
            bus.c2_in = v.c2[k];
            bus.r2_in = v.r2[k];
            tick();
        end
        bus.load = 1'b0;
    endtask

    task automatic start_pulse();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.load  = 1'b0;
    endtask

    // Starts a frame and checks timing and bits; returns at the done cycle.
    task automatic run_check(input logic [N-1:0] exp, input string nm, input bit disturb);
        int t0;
        int first_v;
        int done_c;
        int nv;
        logic [N-1:0] got;
        t0 = cyc;
        start_pulse();
        chk({nm, ".busy_after_start"}, int'(bus.busy), 1);
        first_v = -1;
        done_c  = -1;
        nv      = 0;
        got     = '0;
        for (int g = 0; g < MC + N + 10 && done_c < 0; g++) begin
            if (bus.valid) begin
                if (first_v < 0) first_v = cyc - t0;
                if (nv < N) got[nv] = bus.message_out;
                nv++;
            end
            if (bus.done) begin
                done_c = cyc - t0;
                chk({nm, ".busy_at_done"}, int'(bus.busy), 0);
            end
            if (disturb && (cyc - t0) < MC) begin
                bus.load  = 1'($urandom);
                bus.start = 1'($urandom);
                bus.c1_in = LOGQ'($urandom);
                bus.c2_in = LOGQ'($urandom);
                bus.r2_in = RW'($urandom);
            end else begin
                bus.load  = 1'b0;
                bus.start = 1'b0;
            end
            if (done_c < 0) tick();
        end
        chk({nm, ".first_valid"}, first_v, MC + 1);
        chk({nm, ".valid_count"}, nv, N);
        chk({nm, ".bits"}, int'(got), int'(exp));
        chk({nm, ".done_cycle"}, done_c, MC + N + 1);
    endtask

    vec_t tbl [3];
    vec_t rv;

    initial begin
        bus.load  = 1'b0;
        bus.start = 1'b0;
        bus.c1_in = '0;
        bus.c2_in = '0;
        bus.r2_in = '0;

        // RW'(3) is +1 in a binary build and -1 (2'b11) in a ternary build.
        tbl[0].c1 = '{8'd1, 8'd2, 8'd3, 8'd4};
        tbl[0].c2 = '{8'd64, 8'd0, 8'd128, 8'd192};
        tbl[0].r2 = '{RW'(0), RW'(3), RW'(0), RW'(0)};
`ifdef RBLWE_TERNARY_EN
        tbl[0].bits = 4'b1101;   // acc = 68,255,126,189
`else
        tbl[0].bits = 4'b0100;   // acc = 60,1,130,195
`endif
        tbl[1].c1   = '{8'd1, 8'd2, 8'd3, 8'd4};
        tbl[1].c2   = '{8'd64, 8'd64, 8'd64, 8'd64};
        tbl[1].r2   = '{RW'(0), RW'(0), RW'(0), RW'(1)};
        tbl[1].bits = 4'b1000;   // acc = 62,61,60,65
        tbl[2].c1   = '{8'd255, 8'd128, 8'd1, 8'd0};
        tbl[2].c2   = '{8'd0, 8'd0, 8'd0, 8'd0};
        tbl[2].r2   = '{RW'(1), RW'(1), RW'(0), RW'(0)};
        tbl[2].bits = 4'b0110;   // acc = 255,127,129,1

        // Reset state
        tick(); tick();
        chk("reset.busy", int'(bus.busy), 0);
        chk("reset.valid", int'(bus.valid), 0);
        chk("reset.done", int'(bus.done), 0);
        chk("reset.message_out", int'(bus.message_out), 0);
        reset_n = 1'b1;
        tick();

        // start with nothing loaded is ignored
        start_pulse();
        chk("noload.busy", int'(bus.busy), 0);

        // Directed table
        for (int i = 0; i < 3; i++) begin
            load_range(tbl[i], 0, N - 1);
            run_check(tbl[i].bits, $sformatf("vec%0d", i), 1'b0);
        end

        // A consumed frame cannot be restarted without a reload
        start_pulse();
        chk("consumed.busy", int'(bus.busy), 0);

        // start after N-1 loads is ignored; completing the frame then works
        load_range(tbl[2], 0, N - 2);
        start_pulse();
        chk("partial.busy", int'(bus.busy), 0);
        load_range(tbl[2], N - 1, N - 1);
        run_check(tbl[2].bits, "partial", 1'b0);

        // start and load together: the load (which would flip bit 0) is dropped
        load_range(tbl[2], 0, N - 1);
        bus.load  = 1'b1;
        bus.c1_in = 8'd255;
        bus.c2_in = 8'h80;
        bus.r2_in = RW'(1);
        run_check(tbl[2].bits, "start_and_load", 1'b0);

        // load/start noise during MULT has no effect
        load_range(tbl[0], 0, N - 1);
        run_check(tbl[0].bits, "mult_noise", 1'b1);

        // Reset at MULT midpoint aborts immediately
        load_range(tbl[1], 0, N - 1);
        start_pulse();
        for (int c = 0; c < MC / 2; c++) tick();
        reset_n = 1'b0;
        #1;
        chk("midreset.busy", int'(bus.busy), 0);
        chk("midreset.valid", int'(bus.valid), 0);
        chk("midreset.message_out", int'(bus.message_out), 0);
        tick(); tick();
        reset_n = 1'b1;
        begin
            int spurious = 0;
            for (int c = 0; c < MC + N + 4; c++) begin
                if (bus.valid || bus.done || bus.busy) spurious++;
                tick();
            end
            chk("midreset.spurious", spurious, 0);
        end
        load_range(tbl[0], 0, N - 1);
        run_check(tbl[0].bits, "after_reset", 1'b0);

        // Random frames against the model
        for (int it = 0; it < 40; it++) begin
            for (int k = 0; k < N; k++) begin
                rv.c1[k] = LOGQ'($urandom);
                rv.c2[k] = LOGQ'($urandom);
                rv.r2[k] = RW'($urandom);
            end
            load_range(rv, 0, N - 1);
            run_check(model(rv), $sformatf("rand%0d", it), it[0]);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rblwe_decrypt_core.md
# rblwe_decrypt_core

Parametrised Ring-Binary-LWE decryption core. It computes m = decode(c1·r2 + c2) in Z_q[x]/(x^N+1), with q = 2^LOGQ, using P parallel multiply-accumulate lanes. It generalises the fixed 256-coefficient, 8-bit serial decryptor to configurable degree, coefficient width and lane count, and adds busy/done handshaking. Ciphertext and key coefficients stream in one per cycle; message bits stream out one per cycle.

## Interface
- N, 256, ring degree (power of 2, ≥4)
- LOGQ, 8, coefficient width; q = 2^LOGQ (≥3)
- P, 4, MAC lanes (power of 2, divides N)
- RW, 1 (2 with RBLWE_TERNARY_EN), r2 coefficient width (derived, not user-set)

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- load  in  1  coefficient-load strobe, one coefficient per cycle
- c1_in  in  LOGQ  c1 coefficient (index = load count)
- c2_in  in  LOGQ  c2 coefficient
- r2_in  in  RW  r2 coefficient
- start  in  1  begin decryption (level-sampled)
- busy  out  1  high in MULT and OUT
- message_out  out  1  decoded message bit
- valid  out  1  message_out qualifier
- done  out  1  one-cycle pulse after the last output bit

## Operation
- States: IDLE, MULT, OUT.
- IDLE, load=1: write c1_in→c1[k], r2_in→r2[k], c2_in→acc[k] (the accumulator is pre-seeded with c2), k = load count; count increments. If count==N, the next load restarts at k=0 (new frame overwrites).
- start is accepted only in IDLE with count==N; otherwise it is ignored. On acceptance, count clears and the state becomes MULT. load and start are ignored while busy.
- MULT: for j = 0..N-1 (outer), for each block of P accumulator indices (inner, N/P cycles): acc[k] += s·c1[(k−j) mod N], with s = −1 when k<j (negacyclic wrap), scaled by r2[j] ∈ {0,1} (or {−1,0,1} when ternary). All arithmetic is mod 2^LOGQ, truncating to LOGQ bits with no saturation.
- OUT: for i = 0..N-1, message_out = acc[i][LOGQ-1] XOR acc[i][LOGQ-2] (1 iff acc ∈ [q/4, 3q/4)), valid=1, coefficient 0 first. After bit N-1, done pulses and the state returns to IDLE.
- Coefficient memories persist; only acc is consumed. Reloading all N coefficients is required before each start.

## Timing
- Reset (async assert, sync deassert by system): state IDLE, count 0, busy=0, valid=0, message_out=0, done=0. Memory contents are undefined.
- start sampled at edge T0 → busy=1 from T0+1.
- MULT lasts N²/P cycles (T0+1 .. T0+N²/P).
- valid high in cycles T0+N²/P+1 .. T0+N²/P+N, one bit per cycle, with no gaps.
- done=1 in cycle T0+N²/P+N+1; busy falls in the same cycle. A new load is accepted in that cycle.
- Defaults: 16384 MULT cycles + 256 output cycles.
- Reset mid-MULT/OUT: immediate abort. All outputs return to their reset values; no done pulse is issued.
- start and load high together in IDLE with count==N: start wins and that load cycle is discarded.

## Configuration
- RBLWE_TERNARY_EN defined: RW=2 and r2 is ternary. Encoding: 00→0, 01→+1, 11→−1, 10→0. −1 subtracts c1 (with negacyclic sign applied).
- Undefined: RW=1 and r2 is binary; lanes contain no subtract path beyond the wrap sign.

## Structure
- Package rblwe_pkg: state enum, decode function (MSB XOR MSB-1), r2 encoding constants, lane-count/derived-width localparam helpers.
- Sub-module rblwe_mac_lane: one lane. Inputs are acc word, c1 word, wrap flag and r2 coefficient; output is the updated acc word. It is instantiated P times.
- Top level holds the FSM, counters (j, block, output index, load count) and coefficient storage.

## Test plan
- Reset: hold reset_n=0 mid-frame → busy, valid, done, message_out all 0; start without prior load → busy stays 0.
- N=4, LOGQ=8, P=2, binary: c1=[1,2,3,4], r2=[0,1,0,0], c2=[64,0,128,192] → acc=[60,1,130,195], bits 0,0,1,0; valid during cycles T0+9..T0+12; done at T0+13.
- Regression: the five existing 256-coefficient c1/c2/r2/m vectors at P=1, 4 and 16 → all 256 bits match m; first valid at T0+N²/P+1.
- Protocol: start after only 255 loads → ignored; load and start pulses during MULT → no effect on the result.
- Reset at MULT midpoint, then a full reload and start of vector 0 → correct m; no spurious valid or done.
- RBLWE_TERNARY_EN, N=4: c1=[1,2,3,4], r2=[0,−1,0,0] (r2_in=2'b11 at k=1), c2=[64,0,128,192] → acc=[68,255,126,189], bits 1,0,1,1.
